beep_tone_decoder: RTL and testbench



---
 rtl/beep_tone_decoder.sv | 202 ++++++++++++++++++++
 tb/tb_beep_tone_decoder.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/beep_tone_decoder.sv
// beep_tone_decoder: measures the period of a square-wave input, matches it against the
// 16-entry note-cycle table and reports a locked key with lock/unlock hysteresis and silence timeout.
`default_nettype none

module beep_tone_decoder #(
  parameter int LOCK_CNT  = 4,
  parameter int TOL_SHIFT = 6,
  parameter int TIMEOUT   = 60000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sig_in,
  output logic [15:0] key_out,
  output logic [3:0]  note_idx,
  output logic        note_valid,
  output logic        new_note,
  output logic [15:0] period
);

  localparam logic [2:0]  LOCK_N   = 3'(LOCK_CNT);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  function automatic logic [15:0] note_cycle(input logic [3:0] i);
    case (i)
      4'd0:    note_cycle = 16'd45872;
      4'd1:    note_cycle = 16'd40858;
      4'd2:    note_cycle = 16'd36408;
      4'd3:    note_cycle = 16'd34364;
      4'd4:    note_cycle = 16'd30612;
      4'd5:    note_cycle = 16'd27273;
      4'd6:    note_cycle = 16'd24296;
      4'd7:    note_cycle = 16'd22931;
      4'd8:    note_cycle = 16'd20432;
      4'd9:    note_cycle = 16'd18201;
      4'd10:   note_cycle = 16'd17180;
      4'd11:   note_cycle = 16'd15306;
      4'd12:   note_cycle = 16'd13636;
      4'd13:   note_cycle = 16'd12148;
      4'd14:   note_cycle = 16'd11478;
      default: note_cycle = 16'd10215;
    endcase
  endfunction

  state_t      state, state_nxt;
  logic        s1, s2, s3;
  logic [15:0] cnt, cnt_nxt;
  logic [3:0]  cand, cand_nxt;
  logic [2:0]  match_cnt, match_cnt_nxt;
  logic [2:0]  miss_cnt, miss_cnt_nxt;
  logic [15:0] key_nxt;
  logic [3:0]  note_idx_nxt;
  logic        note_valid_nxt;
  logic        new_note_nxt;
  logic [15:0] period_nxt;

  logic        edge_det;
  logic        timeout;
  logic [15:0] cap;
  logic        hit;
  logic [3:0]  idx;
  logic [16:0] diff;
  logic [16:0] abs_diff;
  logic [16:0] tol;
  logic [2:0]  m_new;
  logic [2:0]  x_new;
  logic [3:0]  c_new;

  assign edge_det = s2 & ~s3;
  assign timeout  = (cnt == TO_LAST) & ~edge_det;
  assign cap      = (cnt == 16'hFFFF) ? 16'hFFFF : cnt + 16'd1;

  // Scan from the top so that the lowest matching index is the one left standing.
  always_comb begin
    hit      = 1'b0;
    idx      = 4'd0;
    diff     = 17'd0;
    abs_diff = 17'd0;
    tol      = 17'd0;
    for (int i = 15; i >= 0; i--) begin
      diff     = {1'b0, cap} - {1'b0, note_cycle(4'(i))};
      abs_diff = diff[16] ? (~diff + 17'd1) : diff;
      tol      = {1'b0, note_cycle(4'(i))} >> TOL_SHIFT;
      if (abs_diff <= tol) begin
        hit = 1'b1;
        idx = 4'(i);
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = edge_det ? 16'd0 : ((cnt == 16'hFFFF) ? cnt : cnt + 16'd1);
    cand_nxt       = cand;
    match_cnt_nxt  = match_cnt;
    miss_cnt_nxt   = miss_cnt;
    key_nxt        = key_out;
    note_idx_nxt   = note_idx;
    note_valid_nxt = note_valid;
    new_note_nxt   = 1'b0;
    period_nxt     = period;
    m_new          = 3'd0;
    x_new          = 3'd0;
    c_new          = cand;

    if (edge_det && state != ST_IDLE) period_nxt = cap;

    case (state)
      ST_IDLE: begin
        if (edge_det) begin
          state_nxt     = ST_ACQUIRE;
          match_cnt_nxt = 3'd0;
          miss_cnt_nxt  = 3'd0;
        end
      end
      ST_ACQUIRE: begin
        if (edge_det) begin
          c_new         = hit ? idx : cand;
          m_new         = !hit ? 3'd0 : ((idx == cand) ? match_cnt + 3'd1 : 3'd1);
          cand_nxt      = c_new;
          match_cnt_nxt = m_new;
          if (m_new == LOCK_N) begin
            state_nxt      = ST_LOCKED;
            key_nxt        = 16'h0001 << c_new;
            note_idx_nxt   = c_new;
            note_valid_nxt = 1'b1;
            new_note_nxt   = 1'b1;
            miss_cnt_nxt   = 3'd0;
          end
        end else if (timeout) begin
          state_nxt     = ST_IDLE;
          match_cnt_nxt = 3'd0;
          miss_cnt_nxt  = 3'd0;
        end
      end
      ST_LOCKED: begin
        if (edge_det) begin
          x_new        = (hit && idx == cand) ? 3'd0 : miss_cnt + 3'd1;
          miss_cnt_nxt = x_new;
          // The capture that breaks the lock also seeds the next acquisition.
          if (x_new == LOCK_N) begin
            state_nxt      = ST_ACQUIRE;
            key_nxt        = 16'd0;
            note_idx_nxt   = 4'd0;
            note_valid_nxt = 1'b0;
            miss_cnt_nxt   = 3'd0;
            cand_nxt       = hit ? idx : cand;
            match_cnt_nxt  = hit ? 3'd1 : 3'd0;
          end
        end else if (timeout) begin
          state_nxt      = ST_IDLE;
          key_nxt        = 16'd0;
          note_idx_nxt   = 4'd0;
          note_valid_nxt = 1'b0;
          match_cnt_nxt  = 3'd0;
          miss_cnt_nxt   = 3'd0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      state      <= ST_IDLE;
      cnt        <= 16'd0;
      cand       <= 4'd0;
      match_cnt  <= 3'd0;
      miss_cnt   <= 3'd0;
      key_out    <= 16'd0;
      note_idx   <= 4'd0;
      note_valid <= 1'b0;
      new_note   <= 1'b0;
      period     <= 16'd0;
    end else begin
      s1         <= sig_in;
      s2         <= s1;
      s3         <= s2;
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      cand       <= cand_nxt;
      match_cnt  <= match_cnt_nxt;
      miss_cnt   <= miss_cnt_nxt;
      key_out    <= key_nxt;
      note_idx   <= note_idx_nxt;
      note_valid <= note_valid_nxt;
      new_note   <= new_note_nxt;
      period     <= period_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_beep_tone_decoder.sv
// Directed bench for beep_tone_decoder: lock, tolerance edges, note change, silence, glitch, reset.
`default_nettype none

module tb_beep_tone_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        sig_in;
  logic [15:0] key_out;
  logic [3:0]  note_idx;
  logic        note_valid;
  logic        new_note;
  logic [15:0] period;

  int checks   = 0;
  int failures = 0;
  int nn_count = 0;
  int nn_base  = 0;

  beep_tone_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .sig_in     (sig_in),
    .key_out    (key_out),
    .note_idx   (note_idx),
    .note_valid (note_valid),
    .new_note   (new_note),
    .period     (period)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (new_note === 1'b1) nn_count++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One rise-to-rise period of p clocks, 50% duty, starting with the rise.
  task automatic tone(input int p);
    sig_in = 1'b1;
    repeat (p / 2) @(negedge clk);
    sig_in = 1'b0;
    repeat (p - p / 2) @(negedge clk);
  endtask

  task automatic tones(input int p, input int n);
    for (int k = 0; k < n; k++) tone(p);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    sig_in = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_key", 32'(key_out), 32'h0);
    check_val("rst_idx", 32'(note_idx), 32'h0);
    check_val("rst_valid", 32'(note_valid), 32'h0);
    check_val("rst_new", 32'(new_note), 32'h0);
    check_val("rst_period", 32'(period), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Lock on 27273: first edge only restarts the counter
    tone(27273);
    check_val("first_edge_period", 32'(period), 32'h0);
    check_val("first_edge_valid", 32'(note_valid), 32'h0);
    tones(27273, 3);
    check_val("pre_lock_valid", 32'(note_valid), 32'h0);
    nn_base = nn_count;
    sig_in = 1'b1;
    repeat (2) @(negedge clk);
    check_val("lock_not_yet", 32'(note_valid), 32'h0);
    @(negedge clk);
    check_val("lock_valid", 32'(note_valid), 32'h1);
    check_val("lock_new", 32'(new_note), 32'h1);
    check_val("lock_key", 32'(key_out), 32'h0020);
    check_val("lock_idx", 32'(note_idx), 32'h5);
    check_val("lock_period", 32'(period), 32'd27273);
    @(negedge clk);
    check_val("lock_new_one_cycle", 32'(new_note), 32'h0);
    repeat (27273 / 2 - 4) @(negedge clk);
    sig_in = 1'b0;
    repeat (27273 - 27273 / 2) @(negedge clk);
    check_val("lock_nn_count", 32'(nn_count - nn_base), 32'd1);

    // Note change to 22931; the first call's rise still captures 27273
    nn_base = nn_count;
    tones(22931, 4);
    check_val("chg_still_locked", 32'(key_out), 32'h0020);
    tone(22931);
    check_val("chg_unlock_key", 32'(key_out), 32'h0);
    check_val("chg_unlock_valid", 32'(note_valid), 32'h0);
    tones(22931, 2);
    check_val("chg_acq_valid", 32'(note_valid), 32'h0);
    tone(22931);
    check_val("chg_relock_key", 32'(key_out), 32'h0080);
    check_val("chg_relock_idx", 32'(note_idx), 32'h7);
    check_val("chg_nn_count", 32'(nn_count - nn_base), 32'd1);

    // Move to 15306, then a single 9000 glitch capture
    tones(15306, 8);
    check_val("g_lock_key", 32'(key_out), 32'h0800);
    nn_base = nn_count;
    tone(9000);
    tone(15306);
    check_val("g_glitch_period", 32'(period), 32'd9000);
    check_val("g_glitch_valid", 32'(note_valid), 32'h1);
    tones(15306, 3);
    check_val("g_hold_key", 32'(key_out), 32'h0800);
    check_val("g_period", 32'(period), 32'd15306);
    check_val("g_no_new", 32'(nn_count - nn_base), 32'd0);

    // Reset mid-lock
    pulse_rst();
    check_val("mr_key", 32'(key_out), 32'h0);
    check_val("mr_idx", 32'(note_idx), 32'h0);
    check_val("mr_valid", 32'(note_valid), 32'h0);
    check_val("mr_period", 32'(period), 32'h0);
    tones(15306, 4);
    check_val("mr_not_yet", 32'(note_valid), 32'h0);
    tone(15306);
    check_val("mr_relock_key", 32'(key_out), 32'h0800);

    // Silence on 45872: timeout counted from the last edge
    pulse_rst();
    tones(45872, 5);
    check_val("s_lock_key", 32'(key_out), 32'h0001);
    check_val("s_lock_period", 32'(period), 32'd45872);
    repeat (60002 - 45872) @(negedge clk);
    check_val("s_before_to", 32'(note_valid), 32'h1);
    @(negedge clk);
    check_val("s_to_valid", 32'(note_valid), 32'h0);
    check_val("s_to_key", 32'(key_out), 32'h0);
    check_val("s_to_period", 32'(period), 32'd45872);

    // Tolerance boundary, starting from IDLE after the timeout
    tones(27699, 5);
    check_val("b_27699_key", 32'(key_out), 32'h0020);
    check_val("b_27699_idx", 32'(note_idx), 32'h5);
    pulse_rst();
    nn_base = nn_count;
    tones(27700, 6);
    check_val("b_27700_valid", 32'(note_valid), 32'h0);
    check_val("b_27700_period", 32'(period), 32'd27700);
    tones(26000, 6);
    check_val("b_26000_key", 32'(key_out), 32'h0);
    check_val("b_26000_period", 32'(period), 32'd26000);
    check_val("b_no_new", 32'(nn_count - nn_base), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
